mem_responder: RTL and testbench

Synchronous single-port-style memory responder that serves the summing master's memory bus: it answers `mem_read_enable`/`mem_write_enable` requests on `mem_address`, returning read data one cycle later. After every reset it runs a fill sequencer that writes each word with its own index (or zero), so the master always starts from a known image. It sits between `TOP` and the system boundary, replacing the behavioural memory used in simulation with synthesizable RTL.

---
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder.sv | 125 ++++++++++++
 tb/tb_mem_responder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Memory bus between the summing master and mem_responder: request side
// driven by the master, registered read data and busy status by the responder.
interface mem_responder_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] mem_address;
   logic                  mem_read_enable;
   logic                  mem_write_enable;
   logic [DATA_WIDTH-1:0] mem_data_in;
   logic [DATA_WIDTH-1:0] mem_data_out;
   logic                  mem_data_valid;
   logic                  mem_busy;

   modport master (
      output mem_address, mem_read_enable, mem_write_enable, mem_data_in,
      input  mem_data_out, mem_data_valid, mem_busy
   );

   modport slave (
      input  mem_address, mem_read_enable, mem_write_enable, mem_data_in,
      output mem_data_out, mem_data_valid, mem_busy
   );
endinterface

// File: rtl/mem_responder.sv
// Synchronous memory responder: refills the whole array after every reset,
// then serves read-first reads (latency 1) and writes (latency 0).
module mem_responder #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 16,
   parameter int INIT_MODE  = 1
) (
   input  logic             clk,
   input  logic             reset,
   mem_responder_if.slave   bus,
   output logic [7:0]       wr_count,
   output logic             drop_flag
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_FILL  = 2'd1,
      ST_SERVE = 2'd2
   } state_t;

   state_t                state_r;
   logic [ADDR_WIDTH-1:0] fill_cnt_r;
   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   logic                  mem_we_s;
   logic [ADDR_WIDTH-1:0] mem_wa_s;
   logic [DATA_WIDTH-1:0] mem_wd_s;
   logic                  req_s;
   logic                  fill_last_s;

   function automatic logic [DATA_WIDTH-1:0] fill_pattern(input logic [ADDR_WIDTH-1:0] idx);
      if (INIT_MODE != 0) begin
         return DATA_WIDTH'(idx);
      end else begin
         return {DATA_WIDTH{1'b0}};
      end
   endfunction

   assign req_s       = bus.mem_read_enable | bus.mem_write_enable;
   assign fill_last_s = (fill_cnt_r == {ADDR_WIDTH{1'b1}});

   // Select the single write port source: fill sequencer while busy, master in SERVE.
   always_comb begin
      mem_we_s = 1'b0;
      mem_wa_s = fill_cnt_r;
      mem_wd_s = fill_pattern(fill_cnt_r);
      if (!reset) begin
         mem_we_s = 1'b0;
      end else begin
         case (state_r)
            ST_RESET, ST_FILL: begin
               mem_we_s = 1'b1;
            end
            ST_SERVE: begin
               mem_we_s = bus.mem_write_enable;
               mem_wa_s = bus.mem_address;
               mem_wd_s = bus.mem_data_in;
            end
            default: begin
               mem_we_s = 1'b0;
            end
         endcase
      end
   end

   // Storage array; deliberately not reset, the fill sequencer defines its image.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[mem_wa_s] <= mem_wd_s;
      end
   end

   // Control FSM with registered bus outputs and status counters.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r            <= ST_RESET;
         fill_cnt_r         <= {ADDR_WIDTH{1'b0}};
         bus.mem_data_out   <= {DATA_WIDTH{1'b0}};
         bus.mem_data_valid <= 1'b0;
         bus.mem_busy       <= 1'b1;
         wr_count           <= 8'd0;
         drop_flag          <= 1'b0;
      end else begin
         case (state_r)
            // The release edge already writes word 0, so RESET and FILL share a path.
            ST_RESET, ST_FILL: begin
               fill_cnt_r         <= fill_cnt_r + ADDR_WIDTH'(1);
               bus.mem_data_out   <= {DATA_WIDTH{1'b0}};
               bus.mem_data_valid <= 1'b0;
               if (req_s) begin
                  drop_flag <= 1'b1;
               end
               if (fill_last_s) begin
                  state_r      <= ST_SERVE;
                  bus.mem_busy <= 1'b0;
               end else begin
                  state_r      <= ST_FILL;
                  bus.mem_busy <= 1'b1;
               end
            end
            ST_SERVE: begin
               bus.mem_busy <= 1'b0;
               if (bus.mem_read_enable) begin
                  bus.mem_data_out   <= mem_r[bus.mem_address];
                  bus.mem_data_valid <= 1'b1;
               end else begin
                  bus.mem_data_out   <= {DATA_WIDTH{1'b0}};
                  bus.mem_data_valid <= 1'b0;
               end
               if (bus.mem_write_enable && (wr_count != 8'hFF)) begin
                  wr_count <= wr_count + 8'd1;
               end
            end
            default: begin
               state_r            <= ST_RESET;
               fill_cnt_r         <= {ADDR_WIDTH{1'b0}};
               bus.mem_data_out   <= {DATA_WIDTH{1'b0}};
               bus.mem_data_valid <= 1'b0;
               bus.mem_busy       <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expected read data,
// negedge monitors pop and compare whenever a DUT presents a valid result.
module tb_mem_responder;
   logic       clk;
   logic       reset;
   logic [7:0] wr_count,  wr_count0;
   logic       drop_flag, drop_flag0;

   int checks = 0;
   int passes = 0;
   logic [15:0] exp_q  [$];
   logic [15:0] exp0_q [$];

   mem_responder_if #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) bus  ();
   mem_responder_if #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) bus0 ();

   mem_responder #(.ADDR_WIDTH(5), .DATA_WIDTH(16), .INIT_MODE(1)) dut (
      .clk(clk), .reset(reset), .bus(bus), .wr_count(wr_count), .drop_flag(drop_flag)
   );

   mem_responder #(.ADDR_WIDTH(5), .DATA_WIDTH(16), .INIT_MODE(0)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0), .wr_count(wr_count0), .drop_flag(drop_flag0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end else begin
         passes++;
      end
   endtask

   // Scoreboard monitor for the INIT_MODE=1 instance.
   always @(negedge clk) begin
      if (bus.mem_data_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL read_unexpected: got data %0d, required no result", bus.mem_data_out);
         end else begin
            chk("read_data", 32'(bus.mem_data_out), 32'(exp_q.pop_front()));
         end
      end else if (bus.mem_data_valid === 1'b0 && reset === 1'b1) begin
         chk("idle_out_zero", 32'(bus.mem_data_out), 32'd0);
      end
   end

   // Scoreboard monitor for the INIT_MODE=0 instance.
   always @(negedge clk) begin
      if (bus0.mem_data_valid === 1'b1) begin
         if (exp0_q.size() == 0) begin
            checks++;
            $display("FAIL read0_unexpected: got data %0d, required no result", bus0.mem_data_out);
         end else begin
            chk("read0_data", 32'(bus0.mem_data_out), 32'(exp0_q.pop_front()));
         end
      end
   end

   task automatic cyc(input logic re, input logic we, input logic [4:0] a, input logic [15:0] d);
      bus.mem_read_enable  = re;
      bus.mem_write_enable = we;
      bus.mem_address      = a;
      bus.mem_data_in      = d;
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] a, input logic [15:0] e);
      exp_q.push_back(e);
      cyc(1'b1, 1'b0, a, 16'd0);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (bus.mem_busy !== 1'b0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("fill_done", 32'(bus.mem_busy), 32'd0);
   endtask

   initial begin
      int busy_edges;
      clk = 1'b0;
      reset = 1'b0;
      bus.mem_read_enable = 1'b0;  bus.mem_write_enable = 1'b0;
      bus.mem_address = 5'd0;      bus.mem_data_in = 16'd0;
      bus0.mem_read_enable = 1'b0; bus0.mem_write_enable = 1'b0;
      bus0.mem_address = 5'd0;     bus0.mem_data_in = 16'd0;

      repeat (3) cyc(1'b0, 1'b0, 5'd0, 16'd0);
      chk("rst_out",   32'(bus.mem_data_out),   32'd0);
      chk("rst_valid", 32'(bus.mem_data_valid), 32'd0);
      chk("rst_busy",  32'(bus.mem_busy),       32'd1);
      chk("rst_wr",    32'(wr_count),           32'd0);
      chk("rst_drop",  32'(drop_flag),          32'd0);

      // Busy must cover exactly 32 edges after release.
      reset = 1'b1;
      busy_edges = 0;
      do begin
         @(posedge clk);
         #1;
         busy_edges++;
      end while (bus.mem_busy === 1'b1 && busy_edges < 100);
      chk("busy_edges", 32'(busy_edges), 32'd32);
      chk("drop_clean", 32'(drop_flag), 32'd0);

      bus0.mem_read_enable = 1'b1;
      bus0.mem_address     = 5'd31;
      exp0_q.push_back(16'd0);
      rd(5'd7, 16'd7);
      bus0.mem_read_enable = 1'b0;
      cyc(1'b0, 1'b0, 5'd0, 16'd0);

      cyc(1'b0, 1'b1, 5'd31, 16'd230);
      rd(5'd31, 16'd230);
      chk("wr_count_1", 32'(wr_count), 32'd1);
      exp_q.push_back(16'd4);
      cyc(1'b1, 1'b1, 5'd4, 16'd6);
      rd(5'd4, 16'd6);
      cyc(1'b0, 1'b1, 5'd9, 16'd6);
      chk("wr_count_3", 32'(wr_count), 32'd3);
      rd(5'd9, 16'd6);

      // Second release: master write on the 5th edge lands during FILL.
      reset = 1'b0;
      repeat (2) cyc(1'b0, 1'b0, 5'd0, 16'd0);
      chk("rst2_wr", 32'(wr_count), 32'd0);
      reset = 1'b1;
      repeat (4) cyc(1'b0, 1'b0, 5'd0, 16'd0);
      cyc(1'b0, 1'b1, 5'd3, 16'd99);
      bus.mem_write_enable = 1'b0;
      chk("drop_set", 32'(drop_flag), 32'd1);
      chk("drop_wr",  32'(wr_count),  32'd0);
      wait_ready();
      rd(5'd3, 16'd3);
      cyc(1'b0, 1'b1, 5'd10, 16'h55);
      for (int i = 0; i < 5; i++) begin
         rd(5'(i), 16'(i));
      end
      reset = 1'b0;
      cyc(1'b1, 1'b0, 5'd1, 16'd0);
      chk("midrst_valid", 32'(bus.mem_data_valid), 32'd0);
      chk("midrst_busy",  32'(bus.mem_busy),       32'd1);
      chk("midrst_wr",    32'(wr_count),           32'd0);
      chk("midrst_drop",  32'(drop_flag),          32'd0);
      reset = 1'b1;
      cyc(1'b0, 1'b0, 5'd0, 16'd0);
      wait_ready();
      rd(5'd4, 16'd4);
      rd(5'd10, 16'd10);
      chk("refill_wr", 32'(wr_count), 32'd0);

      // Saturation: 260 writes, address i%32, data i.
      for (int i = 0; i < 260; i++) begin
         cyc(1'b0, 1'b1, 5'(i), 16'(i));
         if (i == 253) chk("wr_count_254", 32'(wr_count), 32'd254);
         if (i == 254) chk("wr_count_255", 32'(wr_count), 32'd255);
      end
      chk("wr_count_sat", 32'(wr_count), 32'd255);
      rd(5'd3, 16'd259);
      rd(5'd4, 16'd228);

      repeat (3) cyc(1'b0, 1'b0, 5'd0, 16'd0);
      chk("scoreboard_drained",  32'(exp_q.size()),  32'd0);
      chk("scoreboard0_drained", 32'(exp0_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
